// File: rtl/alu_issuer.sv
`default_nettype none
// ==========================================================================
// alu_issuer : credit-controlled issuer for a 1-cycle registered ALU with an
//              in-order result FIFO and response watchdog. Define OVF_COUNT_EN
//              to add the o_ovf_count saturating overflow counter.
// Rev 1.0
// ==========================================================================
module alu_issuer #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 4,
  parameter int RES_DEPTH  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [INST_WIDTH-1:0] i_cmd_inst,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  output logic                  o_alu_valid,
  output logic [INST_WIDTH-1:0] o_alu_inst,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_alu_overflow,
  input  logic                  i_alu_valid,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_overflow,
`ifdef OVF_COUNT_EN
  output logic                  o_err,
  output logic [15:0]           o_ovf_count
`else
  output logic                  o_err
`endif
);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_ERR = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  err_q, err_d;
  logic                  alu_valid_q, alu_valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DATA_WIDTH:0]   mem_q [RES_DEPTH];
  logic                  w_accept, w_push, w_pop;
  logic [CNT_W:0]        w_credit_used;

  // Credits are taken from registered state only; a pop in the same cycle is not reused.
  assign w_credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign o_cmd_ready   = (state_q == ST_RUN) && (w_credit_used < (CNT_W+1)'(RES_DEPTH));
  assign w_accept      = i_cmd_valid && o_cmd_ready;
  assign w_pop         = (fifo_cnt_q != '0) && i_res_ready;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    alu_valid_d = w_accept;
    inst_d      = w_accept ? i_cmd_inst : inst_q;
    a_d         = w_accept ? i_cmd_a    : a_q;
    b_d         = w_accept ? i_cmd_b    : b_q;
    w_push      = 1'b0;
    wd_d        = '0;
    inflight_d  = '0;
    if (state_q == ST_RUN) begin
      if (i_alu_valid) begin
        if (inflight_q == '0) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end else if (inflight_q != '0) begin
        wd_d = wd_q + WD_W'(1);
        if (wd_d == WD_W'(TIMEOUT)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      inflight_d = inflight_q + CNT_W'(w_accept) - CNT_W'(w_push);
      if (state_d == ST_ERR) begin
        inflight_d = '0;
      end
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(w_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      err_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      inst_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wd_q        <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      alu_valid_q <= alu_valid_d;
      inst_q      <= inst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wd_q        <= wd_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= {i_alu_overflow, i_alu_data};
      end
    end
  end

`ifdef OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (w_push && i_alu_overflow && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_ovf_count = ovf_cnt_q;
`endif

  assign o_alu_valid    = alu_valid_q;
  assign o_alu_inst     = inst_q;
  assign o_alu_a        = a_q;
  assign o_alu_b        = b_q;
  assign o_res_valid    = (fifo_cnt_q != '0);
  assign o_res_data     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign o_res_overflow = mem_q[rd_ptr_q][DATA_WIDTH];
  assign o_err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issuer.sv
`default_nettype none
// ==========================================================================
// tb_alu_issuer : directed bench with an ALU stub and a transaction-level
//                 result model for alu_issuer.
// Rev 1.0
// ==========================================================================
module tb_alu_issuer;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [IW-1:0] cmd_inst = '0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic          res_ready = 1'b1;
  logic          o_cmd_ready, o_alu_valid, o_res_valid, o_res_overflow, o_err;
  logic [IW-1:0] o_alu_inst;
  logic [DW-1:0] o_alu_a, o_alu_b, o_res_data;
  logic          alu_valid_in = 1'b0, alu_ovf_in = 1'b0;
  logic [DW-1:0] alu_data_in = '0;
  logic          mute = 1'b0, spur = 1'b0;
  logic [15:0]   ovf_count;

  alu_issuer #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .RES_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_inst(cmd_inst),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_alu_valid(o_alu_valid), .o_alu_inst(o_alu_inst), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_data(alu_data_in), .i_alu_overflow(alu_ovf_in), .i_alu_valid(alu_valid_in),
    .o_res_valid(o_res_valid), .i_res_ready(res_ready), .o_res_data(o_res_data),
    .o_res_overflow(o_res_overflow),
`ifdef OVF_COUNT_EN
    .o_err(o_err),
    .o_ovf_count(ovf_count)
`else
    .o_err(o_err)
`endif
  );

`ifndef OVF_COUNT_EN
  assign ovf_count = 16'd0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 15 -> 0, 7 -> multiply (overflow when high half nonzero), others -> signed add.
  function automatic logic [DW:0] alu_fn(input logic [IW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    logic [DW-1:0]   s;
    if (op == 4'd15) return '0;
    if (op == 4'd7) begin
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return {|p[2*DW-1:DW], p[DW-1:0]};
    end
    s = a + b;
    return {(a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]), s};
  endfunction

  always @(posedge clk) begin
    alu_valid_in <= (o_alu_valid && !mute) || spur;
    {alu_ovf_in, alu_data_in} <= alu_fn(o_alu_inst, o_alu_a, o_alu_b);
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: each accepted command becomes visible three cycles later and leaves on pop.
  typedef struct {
    logic [DW-1:0] d;
    logic          o;
    int            rdy;
  } exp_t;
  exp_t          q[$];
  logic          model_on = 1'b0;
  logic          exp_iss_v = 1'b0;
  logic [IW-1:0] ei;
  logic [DW-1:0] ea, eb;

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      logic exp_ready, exp_rv, acc;
      logic [DW:0] r;
      exp_ready = (q.size() < DEPTH);
      exp_rv    = (q.size() > 0) && (q[0].rdy <= cyc);
      check("cmd_ready", o_cmd_ready, exp_ready);
      check("alu_valid", o_alu_valid, exp_iss_v);
      if (exp_iss_v) begin
        check("alu_inst", o_alu_inst, ei);
        check("alu_a", o_alu_a, ea);
        check("alu_b", o_alu_b, eb);
      end
      check("res_valid", o_res_valid, exp_rv);
      if (exp_rv) begin
        check("res_data", o_res_data, q[0].d);
        check("res_ovf", o_res_overflow, q[0].o);
      end
      check("err_clear", o_err, 1'b0);
      if (exp_rv && res_ready) void'(q.pop_front());
      acc = cmd_valid && exp_ready;
      exp_iss_v = acc;
      if (acc) begin
        ei = cmd_inst; ea = cmd_a; eb = cmd_b;
        r = alu_fn(cmd_inst, cmd_a, cmd_b);
        q.push_back('{d: r[DW-1:0], o: r[DW], rdy: cyc + 3});
      end
    end
  end

  logic [DW-1:0] popped[$];
  always @(negedge clk) if (rst_n && o_res_valid && res_ready) popped.push_back(o_res_data);

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [IW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = 1'b1; cmd_inst = op; cmd_a = a; cmd_b = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 1, 0);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [DW-1:0] d, input logic o);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_res_valid) begin
        check({name, "_data"}, o_res_data, d);
        check({name, "_ovf"}, o_res_overflow, o);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0 && !exp_iss_v) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_res_valid", o_res_valid, 0);
    check("rst_alu_valid", o_alu_valid, 0);
    check("rst_err", o_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_iss_v = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] tab_a[6] = '{32'd1, 32'd10, 32'd100, 32'd7, 32'd3, 32'd3};
  logic [DW-1:0] tab_b[6] = '{32'd2, 32'd20, 32'd1,   32'd7, 32'd4, 32'd5};
  logic [IW-1:0] tab_op[6] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd15, 4'd7};
  logic [DW-1:0] tab_exp[6] = '{32'd3, 32'd30, 32'd101, 32'd14, 32'd0, 32'd15};

  initial begin
    int idx, n_low, t0;
    logic acc;
    #1;
    check("reset_alu_valid", o_alu_valid, 0);
    check("reset_res_valid", o_res_valid, 0);
    check("reset_res_data", o_res_data, 0);
    check("reset_err", o_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    model_on = 1'b1;

    // Latency of a single command
    cmd_valid = 1'b1; cmd_inst = 4'd5; cmd_a = 32'd5; cmd_b = 32'd7;
    @(negedge clk); check("lat_ready", o_cmd_ready, 1);
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk); check("lat_alu_valid_t1", o_alu_valid, 1); check("lat_alu_a", o_alu_a, 32'd5);
    @(negedge clk); check("lat_res_valid_t2", o_res_valid, 0);
    @(negedge clk); check("lat_res_valid_t3", o_res_valid, 1); check("lat_data", o_res_data, 32'd12);
    check("lat_ovf", o_res_overflow, 0);
    @(posedge clk); #1;

    send(4'd0, 32'h7FFFFFFF, 32'd1);
    wait_res("add_ovf", 32'h80000000, 1'b1);
    send(4'd7, 32'h00010000, 32'h00010000);
    wait_res("mul_ovf", 32'h0, 1'b1);
    send(4'd15, 32'hDEADBEEF, 32'h12345678);
    wait_res("op15", 32'h0, 1'b0);
    drain();

    // Backpressure: six commands, consumer stalled
    res_ready = 1'b0; idx = 0; popped.delete();
    for (int k = 0; k < 8; k++) begin
      cmd_valid = (idx < 6);
      cmd_inst = tab_op[idx % 6]; cmd_a = tab_a[idx % 6]; cmd_b = tab_b[idx % 6];
      @(negedge clk); acc = cmd_valid && o_cmd_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_accepts", idx, 4);
    check("bp_ready_low", o_cmd_ready, 0);
    res_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 6; k++) begin
      cmd_valid = 1'b1;
      cmd_inst = tab_op[idx]; cmd_a = tab_a[idx]; cmd_b = tab_b[idx];
      @(negedge clk); acc = o_cmd_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    drain();
    check("bp_pop_count", popped.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < popped.size()) check("bp_order", popped[k], tab_exp[k]);
    end

    // Sustained throughput with a ready consumer
    t0 = cyc;
    for (int k = 0; k < 8; k++) send(4'd5, 32'(k), 32'(k * 3));
    check("throughput_cycles", cyc - t0, 8);
    drain();

    // Watchdog: ALU never answers
    model_on = 1'b0; mute = 1'b1;
    send(4'd5, 32'd1, 32'd1);
    n_low = 0;
    for (int k = 0; k < 20 && !o_err; k++) begin
      @(negedge clk);
      if (!o_err) n_low++;
    end
    check("wd_stall_cycles", n_low, TMO);
    check("wd_err", o_err, 1);
    check("wd_ready_low", o_cmd_ready, 0);
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1; check("wd_ready_stays_low", o_cmd_ready, 0);
    check("wd_err_sticky", o_err, 1);
    cmd_valid = 1'b0; mute = 1'b0;
    do_reset();
    check("wd_err_cleared", o_err, 0);

    // Spurious response with one result queued
    res_ready = 1'b0;
    send(4'd5, 32'd40, 32'd2);
    repeat (4) @(posedge clk); #1;
    check("sp_pre_valid", o_res_valid, 1);
    spur = 1'b1; @(posedge clk); #1; spur = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("sp_err", o_err, 1);
    check("sp_ready_low", o_cmd_ready, 0);
    check("sp_res_valid", o_res_valid, 1);
    check("sp_res_data", o_res_data, 32'd42);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("sp_fifo_empty", o_res_valid, 0);
    do_reset();

    // Reset with two in flight and two queued
    res_ready = 1'b0;
    model_on = 1'b1;
    send(4'd5, 32'd1, 32'd1); send(4'd5, 32'd2, 32'd2);
    send(4'd5, 32'd3, 32'd3); send(4'd5, 32'd4, 32'd4);
    @(negedge clk);
    check("mid_queued", o_res_valid, 1);
    @(posedge clk); #1;
    do_reset();
    check("mid_res_valid", o_res_valid, 0);
    check("mid_ready", o_cmd_ready, 1);
    res_ready = 1'b1;
    model_on = 1'b1;
    send(4'd5, 32'd20, 32'd22);
    wait_res("mid_fresh", 32'd42, 1'b0);
    drain();

    for (int k = 0; k < 3; k++) send(4'd0, 32'h7FFFFFFF, 32'd1);
    drain();
`ifdef OVF_COUNT_EN
    check("ovf_count", ovf_count, 16'd3);
`endif
    model_on = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
